// File: rtl/switch_debounce_port.sv
// -----------------------------------------------------------------------------
// switch_debounce_port
//
// Input conditioning between the board switches and the Picoblaze IN_PORT.
// Each switch bit passes through a two-flop synchroniser and a debounce
// counter. A new synchronised level must persist for DEBOUNCE_CYCLES clock
// edges before it is committed to the stable register. Every commit also sets
// the matching bit in a sticky CHANGED mask. Firmware clears CHANGED by
// reading it. Both registers are readable through a registered read mux.
//
// Optional feature (compile-time macro SWITCH_DEBOUNCE_IRQ_EN):
//   When defined, a three-state interrupt FSM (IDLE / PEND / SERVICED)
//   raises INTERRUPT while CHANGED is non-zero and not yet acknowledged.
//   When undefined, INTERRUPT is tied low and INTERRUPT_ACK is ignored.
//
// Parameters
//   WIDTH           switch count (1..8); IN_PORT is zero-extended above WIDTH
//   CNT_WIDTH       debounce counter width
//   DEBOUNCE_CYCLES edges a new level must persist (>=1, < 2**CNT_WIDTH)
//   BASE_ADDR       PORT_ID of the STABLE register; BASE_ADDR+1 is CHANGED
//
// Ports
//   CLK_IN         in   system clock
//   RESET_IN       in   synchronous, active-high reset
//   SWITCHES_IN    in   raw asynchronous switch levels [WIDTH]
//   PORT_ID        in   Picoblaze port address [8]
//   READ_STROBE    in   Picoblaze read strobe (one cycle)
//   IN_PORT        out  registered read data to Picoblaze [8]
//   SWITCHES_OUT   out  debounced stable switch value [WIDTH]
//   INTERRUPT      out  change interrupt (macro builds only, else 0)
//   INTERRUPT_ACK  in   Picoblaze interrupt acknowledge (one cycle)
// -----------------------------------------------------------------------------
module switch_debounce_port #(
    parameter int          WIDTH           = 8,
    parameter int          CNT_WIDTH       = 16,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [7:0]  BASE_ADDR       = 8'h00
) (
    input  logic             CLK_IN,
    input  logic             RESET_IN,
    input  logic [WIDTH-1:0] SWITCHES_IN,
    input  logic [7:0]       PORT_ID,
    input  logic             READ_STROBE,
    output logic [7:0]       IN_PORT,
    output logic [WIDTH-1:0] SWITCHES_OUT,
    output logic             INTERRUPT,
    input  logic             INTERRUPT_ACK
);

    localparam logic [7:0]           CHG_ADDR = BASE_ADDR + 8'd1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     sync1_q, sync1_d;
    logic [WIDTH-1:0]     sync2_q, sync2_d;
    logic [WIDTH-1:0]     stable_q, stable_d;
    logic [WIDTH-1:0]     changed_q, changed_d;
    logic [WIDTH-1:0]     set_mask;
    logic [WIDTH-1:0]     clr_mask;
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
    logic [7:0]           in_port_q, in_port_d;
    logic [7:0]           stable_ext;
    logic [7:0]           changed_ext;

    // Synchroniser: two plain flops per bit.
    always_comb begin
        sync1_d = SWITCHES_IN;
        sync2_d = sync1_q;
    end

    // Debounce: the counter only runs while the synchronised level disagrees
    // with the committed level, so any return to agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        set_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    set_mask[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Sticky change mask. The clear term only removes bits that were already
    // set, and the OR with set_mask afterwards lets a same-cycle commit win.
    always_comb begin
        clr_mask = '0;
        if (READ_STROBE && (PORT_ID == CHG_ADDR)) begin
            clr_mask = changed_q;
        end
        changed_d = (changed_q & ~clr_mask) | set_mask;
    end

    // Registered read mux; PORT_ID is stable for two cycles so the data is
    // already valid when READ_STROBE arrives.
    always_comb begin
        stable_ext              = '0;
        changed_ext             = '0;
        stable_ext[WIDTH-1:0]   = stable_q;
        changed_ext[WIDTH-1:0]  = changed_q;
        if (PORT_ID == BASE_ADDR) begin
            in_port_d = stable_ext;
        end else if (PORT_ID == CHG_ADDR) begin
            in_port_d = changed_ext;
        end else begin
            in_port_d = 8'h00;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            changed_q <= '0;
            in_port_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            in_port_q <= in_port_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign SWITCHES_OUT = stable_q;
    assign IN_PORT      = in_port_q;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_PEND     = 2'd1,
        IRQ_SERVICED = 2'd2
    } irq_state_t;

    irq_state_t irq_state_q, irq_state_d;
    logic       irq_level;

    // SERVICED waits for firmware to read-clear CHANGED before re-arming, so
    // a change landing after the ACK is reported once the mask is drained.
    always_comb begin
        irq_state_d = irq_state_q;
        irq_level   = 1'b0;
        case (irq_state_q)
            IRQ_IDLE: begin
                if (|changed_q) begin
                    irq_state_d = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                irq_level = 1'b1;
                if (INTERRUPT_ACK) begin
                    irq_state_d = IRQ_SERVICED;
                end
            end
            IRQ_SERVICED: begin
                if (changed_q == '0) begin
                    irq_state_d = IRQ_IDLE;
                end
            end
            default: begin
                irq_state_d = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            irq_state_q <= IRQ_IDLE;
        end else begin
            irq_state_q <= irq_state_d;
        end
    end

    assign INTERRUPT = irq_level;
`else
    logic unused_ack;

    assign unused_ack = INTERRUPT_ACK;
    assign INTERRUPT  = 1'b0;
`endif

endmodule
